instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, instruction-memory word-address width.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous active-low.
REQ-004 SHALL have port: imem_req  output  1  read request to instruction memory this cycle.
REQ-005 SHALL have port: imem_addr  output  ADDR_W  word address of the request.
REQ-006 SHALL have port: imem_rdata  input  16  read data, valid exactly one cycle after imem_req.
REQ-007 SHALL have port: inst_valid  output  1  instruction word offered to control unit.
REQ-008 SHALL have port: inst_ready  input  1  control unit accepts the offered word.
REQ-009 SHALL have port: inst_data  output  16  instruction {opp[15:11], R1[10:8], R2[7:5], QR[4:2], RES[1:0]}.
REQ-010 SHALL have port: inst_pc  output  ADDR_W  address of inst_data.
REQ-011 SHALL have port: redir_valid  input  1  jump taken (JMP/JGO/JLO/JEO/RST resolved by control).
REQ-012 SHALL have port: redir_addr  input  ADDR_W  jump target.
REQ-013 SHALL have port: resume  input  1  single-cycle pulse leaving HALT.
REQ-014 SHALL have port: halted  output  1  HALT state reached and buffer drained.

Function
REQ-015 SHALL buffer fetched words in a 2-entry in-order FIFO; head drives inst_data/inst_pc; inst_valid = FIFO non-empty.
REQ-016 SHALL pop the head on inst_valid && inst_ready; inst_data/inst_pc stable while inst_valid && !inst_ready.
REQ-017 SHALL assert imem_req in RUN when (count + inflight) < 2, or == 2 with a pop this cycle; imem_addr = pc; pc increments by 1 modulo 2^ADDR_W (0xFF -> 0x00 at default).
REQ-018 SHALL push {imem_rdata, issued address} into the FIFO the cycle after an un-killed request.
REQ-019 SHALL sustain one instruction per cycle with inst_ready held high; first inst_valid two cycles after first imem_req.
REQ-020 SHALL, on redir_valid: empty FIFO, kill any in-flight response, pc <= redir_addr, state <= RUN, issue at redir_addr next cycle; redirect beats simultaneous pop, push, HLT detection and resume.
REQ-021 SHALL, when a pushed word has opp == OP_HLT (5'd16): enter HALT, stop issuing, kill the younger in-flight response, pc <= HLT address + 1; HLT word itself is still delivered.
REQ-022 SHALL assert halted when state == HALT and FIFO empty.
REQ-023 SHALL, on resume in HALT, return to RUN and fetch from pc next cycle; resume in RUN ignored.
REQ-024 SHALL use states RUN and HALT only; RUN->HALT per REQ-021; HALT->RUN per REQ-020 or REQ-023.

Reset
REQ-025 SHALL, while rst_n low: pc=0, state RUN, FIFO empty, inflight=0, imem_req=0, imem_addr=0, inst_valid=0, inst_data=0, inst_pc=0, halted=0.
REQ-026 SHALL issue address 0 the first clock edge after rst_n deasserts; a response in flight at reset assertion is discarded.

Configuration
REQ-027 SHALL, with IFETCH_STALL_CNT_EN defined, add port stall_cnt output 16: counts cycles with inst_valid && !inst_ready, saturates at 0xFFFF, reset 0, cleared on redirect.
REQ-028 SHALL, without IFETCH_STALL_CNT_EN, omit stall_cnt port and counter entirely; other behaviour identical.

Structure
REQ-029 SHALL take opcode codes (NOP=0, ADD=1 .. MOV=11, JMP=12, JGO=13, JLO=14, JEO=15, HLT=16, RST=17, SETH=18, SETL=19) and instruction field positions from shared package ctrl_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module ifetch_fifo (push, pop, flush, count, head).

Verification
REQ-031 SHALL cover: reset release, ready=1, memory[a]=a -> imem_addr 0,1,2..; inst_pc 0,1,2.. one per cycle from cycle 3.
REQ-032 SHALL cover: ready low 5 cycles after first word -> inst_data held, imem_req stops at count+inflight=2, no word lost or duplicated; stall_cnt=5 when enabled.
REQ-033 SHALL cover: redir_valid with redir_addr=0x40 while FIFO holds 2 words and one in flight -> none of them delivered, next inst_pc 0x40.
REQ-034 SHALL cover: HLT at 0x05 -> delivered with inst_pc 0x05, word at 0x06 not delivered, halted=1 after pop; resume -> next inst_pc 0x06.
REQ-035 SHALL cover: pc 0xFE, no redirects -> inst_pc 0xFE, 0xFF, 0x00.
REQ-036 SHALL cover: rst_n low mid-stream with FIFO full -> all outputs 0 immediately; after release, fetch restarts at 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: opcode codes, instruction field positions
// and the fetch state encoding.
package ctrl_pkg;

    localparam int INST_W  = 16;
    localparam int OPP_MSB = 15;
    localparam int OPP_LSB = 11;
    localparam int R1_MSB  = 10;
    localparam int R1_LSB  = 8;
    localparam int R2_MSB  = 7;
    localparam int R2_LSB  = 5;
    localparam int QR_MSB  = 4;
    localparam int QR_LSB  = 2;
    localparam int RES_MSB = 1;
    localparam int RES_LSB = 0;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_AND  = 5'd3,
        OP_OR   = 5'd4,
        OP_XOR  = 5'd5,
        OP_NOT  = 5'd6,
        OP_SHL  = 5'd7,
        OP_SHR  = 5'd8,
        OP_CMP  = 5'd9,
        OP_LD   = 5'd10,
        OP_MOV  = 5'd11,
        OP_JMP  = 5'd12,
        OP_JGO  = 5'd13,
        OP_JLO  = 5'd14,
        OP_JEO  = 5'd15,
        OP_HLT  = 5'd16,
        OP_RST  = 5'd17,
        OP_SETH = 5'd18,
        OP_SETL = 5'd19
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic [4:0] inst_opp(input logic [INST_W-1:0] word);
        return word[OPP_MSB:OPP_LSB];
    endfunction

    function automatic logic is_halt(input logic [INST_W-1:0] word);
        return inst_opp(word) == OP_HLT;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry in-order buffer between instruction memory and the control unit.
// Entry 0 is always the head; a pop shifts entry 1 down.
module ifetch_fifo #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = wdata;
                    else                 ent1_d = wdata;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = wdata;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = wdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = ent0_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: streams words from instruction memory into a 2-deep buffer,
// handles redirects and HLT. Define IFETCH_STALL_CNT_EN to add the stall_cnt port.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_RUN  | fetching sequentially from pc whenever buffer space allows
//  ST_HALT | HLT word fetched; no requests until resume or redirect
module instr_fetch
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [15:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_addr,
    input  logic              resume,
    output logic              halted
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int                ENT_W  = INST_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
    logic              infl_q, infl_d;
    logic              active_q, active_d;

    logic [1:0]        fifo_count;
    logic [ENT_W-1:0]  fifo_head;
    logic              fifo_push;
    logic              fifo_pop;
    logic              pop_hs;
    logic [1:0]        occ;
    logic              can_issue;
    logic              hlt_seen;

    ifetch_fifo #(
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redir_valid),
        .wdata ({imem_rdata, infl_addr_q}),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign inst_valid = (fifo_count != 2'd0);
    assign inst_data  = fifo_head[ENT_W-1:ADDR_W];
    assign inst_pc    = fifo_head[ADDR_W-1:0];
    assign halted     = (state_q == ST_HALT) && (fifo_count == 2'd0);

    // Buffered plus outstanding words never exceed two, so occ fits in 2 bits.
    assign pop_hs    = inst_valid && inst_ready;
    assign occ       = fifo_count + {1'b0, infl_q};
    assign can_issue = (occ < 2'd2) || ((occ == 2'd2) && pop_hs);
    assign imem_req  = active_q && (state_q == ST_RUN) && can_issue;
    assign imem_addr = pc_q;

    assign fifo_push = infl_q && !redir_valid;
    assign fifo_pop  = pop_hs && !redir_valid;
    assign hlt_seen  = fifo_push && is_halt(imem_rdata);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        infl_d      = 1'b0;
        infl_addr_d = infl_addr_q;
        active_d    = 1'b1;
        if (imem_req) begin
            infl_d      = 1'b1;
            infl_addr_d = pc_q;
            pc_d        = pc_q + PC_ONE;
        end
        // A redirect drops any request issued this cycle along with everything buffered.
        if (redir_valid) begin
            state_d = ST_RUN;
            pc_d    = redir_addr;
            infl_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hlt_seen) begin
                        state_d = ST_HALT;
                        infl_d  = 1'b0;
                        pc_d    = infl_addr_q + PC_ONE;
                    end
                end
                ST_HALT: begin
                    if (resume) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            active_q    <= active_d;
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (redir_valid) begin
            stall_cnt_d = 16'd0;
        end else if (inst_valid && !inst_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= 16'd0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: the expected instruction stream is derived from a memory
// image and queued on each start/redirect/resume; a monitor checks every offered word.
module tb_instr_fetch;

    localparam logic [4:0] HLT = 5'd16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [7:0]  inst_pc;
    logic        redir_valid;
    logic [7:0]  redir_addr;
    logic        resume;
    logic        halted;
`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .resume      (resume),
        .halted      (halted)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    // Memory returns data one cycle after a request; garbage otherwise.
    logic [15:0] mem [256];
    always @(posedge clk) imem_rdata <= imem_req ? mem[imem_addr] : 16'($urandom);

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         stream_halts = 1'b0;
    logic [7:0] resume_pc = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Program order from start: sequential words up to and including the first HLT.
    task automatic fill_stream(input logic [7:0] start);
        logic [7:0] a;
        a = start;
        exp_q.delete();
        stream_halts = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back({a, mem[a]});
            if (mem[a][15:11] == HLT) begin
                stream_halts = 1'b1;
                resume_pc    = a + 8'd1;
                break;
            end
            a = a + 8'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redir_valid = 1'b0;
        resume      = 1'b0;
        inst_ready  = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        @(negedge clk);
        fill_stream(8'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max, input string name);
        int n;
        n = 0;
        while (!inst_valid && n < max) begin
            tick();
            n++;
        end
        if (!inst_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no inst_valid within %0d cycles, required inst_valid=1", name, max);
        end
    endtask

    // Monitor: every offered word must equal the head of the expected stream.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && inst_valid && !redir_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got pc 0x%0h data 0x%0h, required no word", inst_pc, inst_data);
                end else begin
                    chk("inst_pc", inst_pc, exp_q[0].pc);
                    chk("inst_data", inst_data, exp_q[0].data);
                    if (inst_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;
        int n;
        rst_n       = 1'b0;
        inst_ready  = 1'b1;
        redir_valid = 1'b0;
        redir_addr  = 8'd0;
        resume      = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a);
        repeat (2) tick();

        chk("reset_imem_req", imem_req, 0);
        chk("reset_imem_addr", imem_addr, 0);
        chk("reset_inst_valid", inst_valid, 0);
        chk("reset_inst_data", inst_data, 0);
        chk("reset_inst_pc", inst_pc, 0);
        chk("reset_halted", halted, 0);
`ifdef IFETCH_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 0);
`endif

        // Reset release and sustained streaming
        @(negedge clk);
        fill_stream(8'd0);
        rst_n = 1'b1;
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);
        chk("no_valid_c1", inst_valid, 0);
        tick();
        chk("addr_c2", imem_addr, 1);
        chk("no_valid_c2", inst_valid, 0);
        tick();
        chk("valid_c3", inst_valid, 1);
        chk("pc_c3", inst_pc, 0);
        chk("addr_c3", imem_addr, 2);
        tick();
        chk("pc_c4", inst_pc, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        hs = 0;
        repeat (10) begin
            if (inst_valid) hs++;
            tick();
        end
        chk("throughput", hs, 10);

        // Consumer stall for five cycles
        do_reset();
        wait_valid(20, "stall_first_valid");
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) chk("stall_no_req", imem_req, 0);
            tick();
        end
        inst_ready = 1'b1;
`ifdef IFETCH_STALL_CNT_EN
        chk("stall_cnt_5", stall_cnt, 5);
`endif
        repeat (10) tick();

        // Redirect with a full buffer and a pop in the same cycle
        inst_ready = 1'b0;
        repeat (4) tick();
        inst_ready  = 1'b1;
        redir_valid = 1'b1;
        redir_addr  = 8'h40;
        fill_stream(8'h40);
        tick();
        redir_valid = 1'b0;
        chk("redir_flushed", inst_valid, 0);
        chk("redir_req", imem_req, 1);
        chk("redir_issue_addr", imem_addr, 8'h40);
`ifdef IFETCH_STALL_CNT_EN
        chk("redir_stall_clr", stall_cnt, 0);
`endif
        wait_valid(10, "redir_valid_wait");
        chk("redir_first_pc", inst_pc, 8'h40);
        repeat (5) tick();

        // Address wrap
        redir_valid = 1'b1;
        redir_addr  = 8'hFE;
        fill_stream(8'hFE);
        tick();
        redir_valid = 1'b0;
        wait_valid(10, "wrap_valid_wait");
        chk("wrap_pc_fe", inst_pc, 8'hFE);
        tick();
        chk("wrap_pc_ff", inst_pc, 8'hFF);
        tick();
        chk("wrap_pc_00", inst_pc, 8'h00);
        repeat (4) tick();

        // HLT at 0x05, then resume
        mem[5] = 16'h8005;
        do_reset();
        n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
        chk("halted", halted, 1);
        chk("halt_drained", exp_q.size(), 0);
        chk("halt_no_req", imem_req, 0);
        repeat (5) tick();
        chk("halted_hold", halted, 1);
        fill_stream(8'd6);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_not_halted", halted, 0);
        wait_valid(10, "resume_valid_wait");
        chk("resume_pc", inst_pc, 8'd6);
        repeat (4) tick();
        mem[5] = 16'd5;

        // Reset asserted mid-stream with a full buffer
        inst_ready = 1'b0;
        repeat (4) tick();
        chk("full_before_rst", inst_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_halted", halted, 0);
        exp_q.delete();
        repeat (2) tick();
        @(negedge clk);
        fill_stream(8'd0);
        inst_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("rst_restart_req", imem_req, 1);
        chk("rst_restart_addr", imem_addr, 0);
        repeat (10) tick();

        // Random program, random back-pressure, redirects and resumes
        for (int a = 0; a < 256; a++) mem[a] = {5'($urandom_range(0, 19)), 11'($urandom)};
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            redir_valid = 1'b0;
            resume      = 1'b0;
            inst_ready  = ($urandom_range(0, 9) < 7);
            chk("halted_model", halted, (exp_q.size() == 0) && stream_halts);
            if ($urandom_range(0, 39) == 0) begin
                redir_valid = 1'b1;
                redir_addr  = 8'($urandom);
                fill_stream(redir_addr);
                resume = 1'($urandom_range(0, 1));
            end else if (halted && $urandom_range(0, 2) == 0) begin
                resume = 1'b1;
                fill_stream(resume_pc);
            end
        end
        tick();
        redir_valid = 1'b0;
        resume      = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
